// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
//   - ALU ctrl encoding, RV32I opcode / funct3 / funct7 constants
//   - operand-select enums produced by alu_op_decode
//   - issue_t: the bundle held in the issue pipeline register
package alu_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] CTRL_AND  = 4'b0000;
    localparam logic [CTRL_W-1:0] CTRL_OR   = 4'b0001;
    localparam logic [CTRL_W-1:0] CTRL_ADD  = 4'b0100;
    localparam logic [CTRL_W-1:0] CTRL_SUB  = 4'b0101;
    localparam logic [CTRL_W-1:0] CTRL_SLT  = 4'b0110;
    localparam logic [CTRL_W-1:0] CTRL_SLTU = 4'b0111;
    localparam logic [CTRL_W-1:0] CTRL_XOR  = 4'b1000;
    localparam logic [CTRL_W-1:0] CTRL_SLL  = 4'b1001;
    localparam logic [CTRL_W-1:0] CTRL_SRL  = 4'b1010;
    localparam logic [CTRL_W-1:0] CTRL_SRA  = 4'b1011;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        A_ZERO,
        A_RS1,
        A_PC
    } a_sel_e;

    typedef enum logic [2:0] {
        B_ZERO,
        B_RS2,
        B_IMM_I,
        B_SHAMT,
        B_IMM_U
    } b_sel_e;

    typedef struct packed {
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        rd;
        logic              rd_we;
        logic              illegal;
    } issue_t;

    // Base (funct7 = 0000000) operation for a funct3 value.
    function automatic logic [CTRL_W-1:0] f3_to_ctrl(input logic [2:0] f3);
        logic [CTRL_W-1:0] c;
        case (f3)
            F3_ADD_SUB: c = CTRL_ADD;
            F3_SLL:     c = CTRL_SLL;
            F3_SLT:     c = CTRL_SLT;
            F3_SLTU:    c = CTRL_SLTU;
            F3_XOR:     c = CTRL_XOR;
            F3_SRL_SRA: c = CTRL_SRL;
            F3_OR:      c = CTRL_OR;
            default:    c = CTRL_AND;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational RV32I ALU-class decoder.
//   opcode, funct3, funct7 : instruction fields
//   ctrl    : ALU operation
//   a_sel   : operand A source (zero / rs1 / pc)
//   b_sel   : operand B source (zero / rs2 / I-imm / shamt / U-imm)
//   illegal : not an ALU-class instruction or malformed funct7
// Illegal encodings are forced to ADD with both operands zero.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic [CTRL_W-1:0] ctrl,
    output a_sel_e            a_sel,
    output b_sel_e            b_sel,
    output logic              illegal
);

    always_comb begin
        ctrl    = CTRL_ADD;
        a_sel   = A_ZERO;
        b_sel   = B_ZERO;
        illegal = 1'b0;

        case (opcode)
            OP_R: begin
                a_sel = A_RS1;
                b_sel = B_RS2;
                if (funct7 == F7_BASE)
                    ctrl = f3_to_ctrl(funct3);
                else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB)
                    ctrl = CTRL_SUB;
                else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA)
                    ctrl = CTRL_SRA;
                else
                    illegal = 1'b1;
            end
            OP_IMM: begin
                a_sel = A_RS1;
                case (funct3)
                    // Shift immediates reuse the funct7 slot of imm[11:5].
                    F3_SLL: begin
                        b_sel = B_SHAMT;
                        if (funct7 == F7_BASE) ctrl = CTRL_SLL;
                        else                   illegal = 1'b1;
                    end
                    F3_SRL_SRA: begin
                        b_sel = B_SHAMT;
                        if (funct7 == F7_BASE)     ctrl = CTRL_SRL;
                        else if (funct7 == F7_ALT) ctrl = CTRL_SRA;
                        else                       illegal = 1'b1;
                    end
                    default: begin
                        b_sel = B_IMM_I;
                        ctrl  = f3_to_ctrl(funct3);
                    end
                endcase
            end
            OP_LUI: begin
                a_sel = A_ZERO;
                b_sel = B_IMM_U;
            end
            OP_AUIPC: begin
                a_sel = A_PC;
                b_sel = B_IMM_U;
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            ctrl  = CTRL_ADD;
            a_sel = A_ZERO;
            b_sel = B_ZERO;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue stage in front of the 32-bit ALU.
//   clk, rst (sync, active-high)
//   in_valid/in_ready, instr, pc     : instruction from fetch
//   rs1_data, rs2_data               : register-file read data
//   ex_fwd_*, wb_fwd_*               : forwarding from EX and WB (EX wins)
//   flush                            : kill held and incoming instruction
//   out_valid/out_ready, input_a, input_b, ctrl, rd, rd_we, illegal
//                                    : registered ALU issue bundle
// Optional build macro ALU_ISSUE_SKID_EN adds a one-entry skid buffer so
// that in_ready is registered and independent of out_ready.
module alu_issue_stage #(
    parameter int XLEN   = 32,  // only 32 is supported
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              ex_fwd_valid,
    input  logic [4:0]        ex_fwd_rd,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic              wb_fwd_valid,
    input  logic [4:0]        wb_fwd_rd,
    input  logic [XLEN-1:0]   wb_fwd_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   input_a,
    output logic [XLEN-1:0]   input_b,
    output logic [CTRL_W-1:0] ctrl,
    output logic [4:0]        rd,
    output logic              rd_we,
    output logic              illegal
);

    import alu_pkg::*;

    // x0 reads as zero and is never forwarded; EX is newer than WB.
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rf,
        input logic            exv,
        input logic [4:0]      exrd,
        input logic [XLEN-1:0] exd,
        input logic            wbv,
        input logic [4:0]      wbrd,
        input logic [XLEN-1:0] wbd
    );
        if (idx == 5'd0)              return '0;
        else if (exv && exrd == idx)  return exd;
        else if (wbv && wbrd == idx)  return wbd;
        else                          return rf;
    endfunction

    // ---- p0: decode and operand resolution (accept cycle) ----
    logic [CTRL_W-1:0]      dec_ctrl_p0;
    a_sel_e                 a_sel_p0;
    b_sel_e                 b_sel_p0;
    logic                   dec_ill_p0;
    logic [XLEN-1:0]        rs1_val_p0;
    logic [XLEN-1:0]        rs2_val_p0;
    logic signed [11:0]     imm12_p0;
    logic signed [XLEN-1:0] imm_i_p0;
    issue_t                 dec_p0;
    logic                   accept_p0;

    alu_op_decode u_dec (
        .opcode  (instr[6:0]),
        .funct3  (instr[14:12]),
        .funct7  (instr[31:25]),
        .ctrl    (dec_ctrl_p0),
        .a_sel   (a_sel_p0),
        .b_sel   (b_sel_p0),
        .illegal (dec_ill_p0)
    );

    assign rs1_val_p0 = resolve(instr[19:15], rs1_data, ex_fwd_valid, ex_fwd_rd,
                                ex_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
    assign rs2_val_p0 = resolve(instr[24:20], rs2_data, ex_fwd_valid, ex_fwd_rd,
                                ex_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
    assign imm12_p0   = instr[31:20];
    assign imm_i_p0   = XLEN'(imm12_p0);

    always_comb begin
        dec_p0 = '0;
        case (a_sel_p0)
            A_RS1:   dec_p0.a = rs1_val_p0;
            A_PC:    dec_p0.a = pc;
            default: dec_p0.a = '0;
        endcase
        case (b_sel_p0)
            B_RS2:   dec_p0.b = rs2_val_p0;
            B_IMM_I: dec_p0.b = imm_i_p0;
            B_SHAMT: dec_p0.b = XLEN'(instr[24:20]);
            B_IMM_U: dec_p0.b = {instr[31:12], 12'b0};
            default: dec_p0.b = '0;
        endcase
        dec_p0.ctrl    = dec_ctrl_p0;
        dec_p0.rd      = instr[11:7];
        dec_p0.rd_we   = !dec_ill_p0 && (instr[11:7] != 5'd0);
        dec_p0.illegal = dec_ill_p0;
    end

    assign accept_p0 = in_valid && in_ready;

    // ---- p1: issue register feeding the ALU ----
    issue_t out_p1;
    logic   vld_p1;

`ifdef ALU_ISSUE_SKID_EN
    issue_t skid_p1;
    logic   skid_vld_p1;
    logic   main_free_p1;

    // Main register can take a new entry when empty or retiring this cycle.
    assign main_free_p1 = !vld_p1 || out_ready;
    assign in_ready     = !skid_vld_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            out_p1      <= '0;
            skid_vld_p1 <= 1'b0;
            skid_p1     <= '0;
        end else if (flush) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (main_free_p1) begin
            // Skid full implies in_ready=0, so no accept competes here.
            if (skid_vld_p1) begin
                vld_p1      <= 1'b1;
                out_p1      <= skid_p1;
                skid_vld_p1 <= 1'b0;
            end else if (accept_p0) begin
                vld_p1 <= 1'b1;
                out_p1 <= dec_p0;
            end else begin
                vld_p1 <= 1'b0;
            end
        end else if (accept_p0) begin
            skid_vld_p1 <= 1'b1;
            skid_p1     <= dec_p0;
        end
    end
`else
    assign in_ready = !vld_p1 || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            out_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1 <= 1'b1;
            out_p1 <= dec_p0;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end
`endif

    assign out_valid = vld_p1;
    assign input_a   = out_p1.a;
    assign input_b   = out_p1.b;
    assign ctrl      = out_p1.ctrl;
    assign rd        = out_p1.rd;
    assign rd_we     = out_p1.rd_we;
    assign illegal   = out_p1.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage directly upstream of the 32-bit ALU.
- Decodes RV32I ALU-class instructions (R-type, I-type ALU, LUI, AUIPC) into the ALU's input_a, input_b and 4-bit ctrl.
- Resolves operands from register-file read data plus EX/WB forwarding.
- Holds the result in a valid/ready pipeline register feeding the ALU.

Parameters:
- XLEN, 32, datapath width; the only supported value is 32.
- CTRL_W, 4, ALU ctrl width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  instruction valid from fetch
- in_ready  out  1  stage can accept
- instr  in  32  instruction word
- pc  in  32  instruction address
- rs1_data  in  32  regfile read port 1 (combinational read of instr[19:15])
- rs2_data  in  32  regfile read port 2 (instr[24:20])
- ex_fwd_valid  in  1  EX result writes a register
- ex_fwd_rd  in  5  EX destination
- ex_fwd_data  in  32  EX result
- wb_fwd_valid  in  1  WB writes a register
- wb_fwd_rd  in  5  WB destination
- wb_fwd_data  in  32  WB result
- flush  in  1  kill held/incoming instruction
- out_valid  out  1  ALU operands valid
- out_ready  in  1  EX accepts
- input_a  out  32  ALU operand A
- input_b  out  32  ALU operand B
- ctrl  out  4  ALU op
- rd  out  5  destination register
- rd_we  out  1  writeback enable
- illegal  out  1  instruction not ALU-class or malformed

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: out_valid, input_a, input_b, ctrl, rd, rd_we and illegal are all 0.
- ctrl encoding (package constants):
  - AND=0000, OR=0001, ADD=0100, SUB=0101, SLT=0110, SLTU=0111
  - XOR=1000, SLL=1001, SRL=1010, SRA=1011
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational).
  - Outputs are registered; latency is 1 cycle from accept to out_valid.
  - Outputs hold stable while out_valid && !out_ready.
  - Accept and retire in the same cycle is allowed (full throughput).
- Operand resolution, per source:
  - Register index 0 gives 0 and forwarding is ignored.
  - Otherwise use ex_fwd_data if ex_fwd_valid && ex_fwd_rd==idx.
  - Otherwise use wb_fwd_data on a WB match.
  - Otherwise use the regfile data.
  - EX has priority over WB.
  - Forwarding is sampled in the accept cycle only.
- Decode:
  - R-type (0110011): a=rs1, b=rs2, ctrl from funct3.
    - funct7=0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
    - Any funct7 other than 0000000 or 0100000 is illegal.
  - I-ALU (0010011): a=rs1, b=sign-extended imm[11:0].
    - SLLI requires funct7=0000000.
    - SRLI/SRAI select on funct7 0000000/0100000; any other funct7 is illegal.
    - For shifts, b = zero-extended shamt[4:0].
  - LUI (0110111): a=0, b={imm[31:12],12'b0}, ADD.
  - AUIPC (0010111): a=pc, b={imm[31:12],12'b0}, ADD.
  - rd_we=1 for legal instructions with rd!=0.
  - Illegal instructions: illegal=1, rd_we=0, ctrl=ADD, a=b=0; they still pass through the handshake.
- flush:
  - Next cycle out_valid=0.
  - Overrides a same-cycle accept; the incoming instruction is dropped.
  - in_ready is unaffected.
- rst mid-transfer discards the held instruction regardless of out_ready.

Optional Feature:
- Macro: ALU_ISSUE_SKID_EN.
- Defined:
  - Adds a 1-entry skid buffer, so in_ready becomes a registered signal (!skid_full) independent of out_ready.
  - An instruction accepted while the output is stalled is decoded into the skid and promoted when out_ready rises.
  - flush and rst clear both entries.
- Undefined: combinational in_ready as above.

Decomposition:
- Package alu_pkg holds:
  - ctrl encoding constants
  - opcode constants (OP_R, OP_IMM, OP_LUI, OP_AUIPC)
  - funct3/funct7 constants
  - XLEN
- One natural sub-module: alu_op_decode, the combinational instr-to-{ctrl, imm select, illegal} decoder, instantiated inside alu_issue_stage.
- Forwarding muxes and the pipeline register stay in the top.

Test Plan:
- addi x1,x0,4 (0x00400093), out_ready=1 → next cycle out_valid=1, a=0, b=4, ctrl=0100, rd=1, rd_we=1.
- add x3,x1,x2 (0x002081B3), rs1_data=4, rs2_data=8 → a=4, b=8, ctrl=0100.
- Same add as sub (0x402081B3) → ctrl=0101.
- add with ex_fwd rd=1 data 0x0000FFFF and wb_fwd rd=1 data 0x1 → a=0x0000FFFF, b=rs2_data.
- Backpressure: out_ready=0 for 2 cycles with a new in_valid → in_ready=0 and outputs frozen; then out_ready=1 → second instruction appears the next cycle.
  - With ALU_ISSUE_SKID_EN: the first extra instruction is accepted into the skid.
- ecall 0x00000073 → illegal=1, rd_we=0.
- flush in the accept cycle → out_valid=0 next cycle.
- rst asserted while stalled → all outputs 0 next cycle.
